lsu_mem_arbiter: RTL and testbench
==================================

Name: lsu_mem_arbiter

Overview:
Shares one data-memory read/write channel among the NUM_LANES per-lane LSUs of a SIMD core. It arbitrates among lane read/write requests with round-robin priority and forwards one transaction at a time to data memory. It then returns the memory acknowledgement, and read data, to the granted lane only. It sits between the LSU array and the data memory controller.

Parameters:
NUM_LANES, 4, number of LSU requesters (power of two, ≥2)
DATA_WIDTH, 64, memory data width
ADDR_WIDTH, 7, memory address width
LANE_W, $clog2(NUM_LANES), lane index width (localparam)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous active-high reset
lane_read_valid  in  NUM_LANES  per-lane read request
lane_write_valid  in  NUM_LANES  per-lane write request
lane_addr  in  NUM_LANES*ADDR_WIDTH  per-lane address; lane i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
lane_write_data  in  NUM_LANES*DATA_WIDTH  per-lane write data, sliced as above
lane_read_ack  out  NUM_LANES  one-cycle read-completion pulse, one-hot
lane_write_ack  out  NUM_LANES  one-cycle write-completion pulse, one-hot
lane_read_data  out  DATA_WIDTH  shared read-return bus; valid while lane_read_ack is non-zero
mem_read_valid  out  1  read request to memory
mem_write_valid  out  1  write request to memory
mem_addr  out  ADDR_WIDTH  memory address
mem_write_data  out  DATA_WIDTH  memory write data
mem_read_ack  in  1  memory read done
mem_write_ack  in  1  memory write done
mem_read_data  in  DATA_WIDTH  memory read data, valid with mem_read_ack
busy  out  1  high in every state except IDLE
grant_lane  out  LANE_W  lane currently or last served

Behaviour:
- Reset: all outputs are 0. State = IDLE, rr_ptr = 0, mask = 0. Reset in any state aborts the transaction and drops mem_*_valid on the next edge. No ack is issued for an aborted transaction.
- All outputs are registered.
- A lane is eligible when (lane_read_valid[i] | lane_write_valid[i]) & ~mask[i].
- The winner is the first eligible lane scanning upward from rr_ptr, wrapping modulo NUM_LANES.
- If a lane asserts both read and write valid, the read is served; the write stays pending.
- States: IDLE, WAIT, RESPOND.
- IDLE:
  - Clear mask.
  - If any lane is eligible: latch winner into grant_lane, latch its addr/data into mem_addr/mem_write_data, set mem_read_valid or mem_write_valid to 1, go to WAIT.
  - Otherwise stay in IDLE.
  - mem_* valid therefore rises one cycle after the lane valid is sampled.
- WAIT:
  - Hold mem_addr, mem_write_data and the mem valid bit stable until the matching ack.
  - On mem_read_ack while reading: capture mem_read_data into lane_read_data, clear mem_read_valid, go to RESPOND.
  - On mem_write_ack while writing: clear mem_write_valid, go to RESPOND.
  - An ack of the wrong type is ignored.
  - There is no timeout; memory is required to ack eventually.
- RESPOND (exactly 1 cycle):
  - lane_read_ack[grant_lane] or lane_write_ack[grant_lane] = 1 for this cycle only.
  - rr_ptr <= grant_lane+1 (wraps).
  - mask <= one-hot(grant_lane), so the served lane cannot win on the following IDLE cycle. This covers an LSU whose valid drops one cycle after ack.
  - Go to IDLE.
- Minimum turnaround per transaction: 3 cycles plus memory latency. Ack latency from mem ack to lane ack is 1 cycle.
- lane_read_data holds its last value outside RESPOND. Lanes must sample it only with their ack.
- Requests that arrive in WAIT or RESPOND are not lost. They stay pending because the lane holds valid, and are arbitrated in the next IDLE.
- A lane whose valid drops before it is granted is simply never served (no request latching).
- Fairness: with all lanes requesting continuously, service order is 0,1,2,3,0,… Each lane waits at most NUM_LANES-1 transactions.

Test Plan:
1. Reset, then lane 2 reads addr 0x15; memory acks after 3 cycles with 0xDEADBEEF_00000001 -> mem_read_valid rises 1 cycle after request with mem_addr=0x15; lane_read_ack=4'b0100 for 1 cycle, 1 cycle after mem ack; lane_read_data=0xDEADBEEF_00000001.
2. Lane 1 writes 0x0A←0x1234 -> mem_write_valid=1, mem_addr=0x0A, mem_write_data=0x1234 held until mem_write_ack; then lane_write_ack=4'b0010 pulse; no read ack.
3. All 4 lanes read simultaneously and hold valid until acked -> grants in order 0,1,2,3; exactly one ack per lane; rr_ptr wraps to 0.
4. Lane 3 keeps valid high for 1 cycle after its ack while lane 0 also requests -> lane 0 is served next; lane 3 is not served twice.
5. rst asserted while in WAIT on a read -> mem_read_valid=0 and busy=0 the next cycle; no lane ack; next grant starts from lane 0.
6. Lane 0 asserts read and write together; memory returns a stray mem_write_ack during the read -> the stray ack is ignored; read completes first, then the write is issued.

Source files
------------

// File: rtl/lsu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_mem_arbiter
//
// Shares a single data-memory read/write channel between the per-lane LSUs of
// a SIMD core. Lane requests are arbitrated round-robin. Exactly one
// transaction is in flight at a time. The memory acknowledgement, and read
// data, go back to the granted lane only.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   lane_read_valid    per-lane read request
//   lane_write_valid   per-lane write request
//   lane_addr          per-lane address, lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   lane_write_data    per-lane write data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   lane_read_ack      one-hot, one-cycle read completion pulse
//   lane_write_ack     one-hot, one-cycle write completion pulse
//   lane_read_data     shared read-return bus, valid alongside lane_read_ack
//   mem_read_valid     read request to memory
//   mem_write_valid    write request to memory
//   mem_addr           memory address
//   mem_write_data     memory write data
//   mem_read_ack       memory read completion
//   mem_write_ack      memory write completion
//   mem_read_data      memory read data, valid with mem_read_ack
//   busy               high whenever the arbiter is not idle
//   grant_lane         lane currently or most recently served
// ---------------------------------------------------------------------------
module lsu_mem_arbiter #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_LANES-1:0]             lane_read_valid,
    input  logic [NUM_LANES-1:0]             lane_write_valid,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0]  lane_addr,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  lane_write_data,
    output logic [NUM_LANES-1:0]             lane_read_ack,
    output logic [NUM_LANES-1:0]             lane_write_ack,
    output logic [DATA_WIDTH-1:0]            lane_read_data,
    output logic                             mem_read_valid,
    output logic                             mem_write_valid,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_write_data,
    input  logic                             mem_read_ack,
    input  logic                             mem_write_ack,
    input  logic [DATA_WIDTH-1:0]            mem_read_data,
    output logic                             busy,
    output logic [$clog2(NUM_LANES)-1:0]     grant_lane
);

    localparam int LANE_W = $clog2(NUM_LANES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                  state_q;
    logic [LANE_W-1:0]       rr_ptr_q;
    logic [NUM_LANES-1:0]    mask_q;
    logic                    is_read_q;
    logic [LANE_W-1:0]       grant_q;
    logic [NUM_LANES-1:0]    lane_read_ack_q;
    logic [NUM_LANES-1:0]    lane_write_ack_q;
    logic [DATA_WIDTH-1:0]   lane_read_data_q;
    logic                    mem_read_valid_q;
    logic                    mem_write_valid_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_write_data_q;
    logic                    busy_q;

    logic [NUM_LANES-1:0]    eligible;
    logic [NUM_LANES-1:0]    grant_onehot;
    logic                    win_found_d;
    logic [LANE_W-1:0]       win_lane_d;
    logic [LANE_W-1:0]       scan_idx;
    logic                    win_is_read_d;

    // The mask holds off the lane just served for one IDLE cycle, so an LSU
    // that drops valid a cycle late is not served a second time.
    assign eligible     = (lane_read_valid | lane_write_valid) & ~mask_q;
    assign grant_onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << grant_q;

    // Round-robin pick: the first eligible lane scanning upward from rr_ptr.
    // LANE_W-bit arithmetic wraps naturally because NUM_LANES is a power of two.
    always_comb begin
        win_found_d = 1'b0;
        win_lane_d  = rr_ptr_q;
        scan_idx    = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            scan_idx = rr_ptr_q + LANE_W'(k);
            if (!win_found_d && eligible[scan_idx]) begin
                win_found_d = 1'b1;
                win_lane_d  = scan_idx;
            end
        end
    end

    // A lane asking for both a read and a write gets the read first. Its write
    // stays pending and is arbitrated later.
    assign win_is_read_d = lane_read_valid[win_lane_d];

    // The transaction FSM. Every output comes straight from a register here.
    // The lane ack pulses default low each cycle and are raised only on the
    // WAIT->RESPOND transition, so they last exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            rr_ptr_q          <= '0;
            mask_q            <= '0;
            is_read_q         <= 1'b0;
            grant_q           <= '0;
            lane_read_ack_q   <= '0;
            lane_write_ack_q  <= '0;
            lane_read_data_q  <= '0;
            mem_read_valid_q  <= 1'b0;
            mem_write_valid_q <= 1'b0;
            mem_addr_q        <= '0;
            mem_write_data_q  <= '0;
            busy_q            <= 1'b0;
        end else begin
            lane_read_ack_q  <= '0;
            lane_write_ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    mask_q <= '0;
                    if (win_found_d) begin
                        grant_q           <= win_lane_d;
                        mem_addr_q        <= lane_addr[win_lane_d*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_write_data_q  <= lane_write_data[win_lane_d*DATA_WIDTH +: DATA_WIDTH];
                        is_read_q         <= win_is_read_d;
                        mem_read_valid_q  <= win_is_read_d;
                        mem_write_valid_q <= ~win_is_read_d;
                        busy_q            <= 1'b1;
                        state_q           <= S_WAIT;
                    end
                end
                // Request stays stable until the matching ack. An ack of the
                // other type is ignored.
                S_WAIT: begin
                    if (is_read_q && mem_read_ack) begin
                        lane_read_data_q <= mem_read_data;
                        lane_read_ack_q  <= grant_onehot;
                        mem_read_valid_q <= 1'b0;
                        state_q          <= S_RESPOND;
                    end else if (!is_read_q && mem_write_ack) begin
                        lane_write_ack_q  <= grant_onehot;
                        mem_write_valid_q <= 1'b0;
                        state_q           <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    rr_ptr_q <= grant_q + LANE_W'(1);
                    mask_q   <= grant_onehot;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign lane_read_ack   = lane_read_ack_q;
    assign lane_write_ack  = lane_write_ack_q;
    assign lane_read_data  = lane_read_data_q;
    assign mem_read_valid  = mem_read_valid_q;
    assign mem_write_valid = mem_write_valid_q;
    assign mem_addr        = mem_addr_q;
    assign mem_write_data  = mem_write_data_q;
    assign busy            = busy_q;
    assign grant_lane      = grant_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_arbiter
//
// Self-checking bench for lsu_mem_arbiter with 4 lanes, 64-bit data and 7-bit
// addresses. Single read and write transactions run from a cycle-by-cycle
// vector table. Hand-written sequences cover round-robin order, the served-
// lane mask, reset mid-transaction and a read/write collision on one lane.
// ---------------------------------------------------------------------------
module tb_lsu_mem_arbiter;

    localparam int NL = 4;
    localparam int DW = 64;
    localparam int AW = 7;

    logic            clk;
    logic            rst;
    logic [NL-1:0]   laneReadValid;
    logic [NL-1:0]   laneWriteValid;
    logic [NL*AW-1:0] laneAddrBus;
    logic [NL*DW-1:0] laneDataBus;
    logic [NL-1:0]   lane_read_ack;
    logic [NL-1:0]   lane_write_ack;
    logic [DW-1:0]   lane_read_data;
    logic            mem_read_valid;
    logic            mem_write_valid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_write_data;
    logic            memReadAck;
    logic            memWriteAck;
    logic [DW-1:0]   memReadData;
    logic            busy;
    logic [1:0]      grant_lane;

    // Fixed per-lane address and write data.
    logic [AW-1:0] laneAddr [NL] = '{7'h03, 7'h0A, 7'h15, 7'h2C};
    logic [DW-1:0] laneData [NL] = '{64'hA0A0, 64'h1234, 64'h5555, 64'h7777};

    assign laneAddrBus = {laneAddr[3], laneAddr[2], laneAddr[1], laneAddr[0]};
    assign laneDataBus = {laneData[3], laneData[2], laneData[1], laneData[0]};

    int checks = 0;
    int errors = 0;
    int ackCount [NL] = '{0, 0, 0, 0};

    lsu_mem_arbiter #(.NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .lane_read_valid  (laneReadValid),
        .lane_write_valid (laneWriteValid),
        .lane_addr        (laneAddrBus),
        .lane_write_data  (laneDataBus),
        .lane_read_ack    (lane_read_ack),
        .lane_write_ack   (lane_write_ack),
        .lane_read_data   (lane_read_data),
        .mem_read_valid   (mem_read_valid),
        .mem_write_valid  (mem_write_valid),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_read_ack     (memReadAck),
        .mem_write_ack    (memWriteAck),
        .mem_read_data    (memReadData),
        .busy             (busy),
        .grant_lane       (grant_lane)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every lane ack pulse so sequences can check nobody is served twice.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NL; i++) begin
                if (lane_read_ack[i] || lane_write_ack[i]) ackCount[i] = ackCount[i] + 1;
            end
        end
    end

    typedef struct {
        logic [3:0]  readValid;
        logic [3:0]  writeValid;
        logic        mRdAck;
        logic        mWrAck;
        logic [63:0] mRdData;
        logic        expRdValid;
        logic        expWrValid;
        logic [6:0]  expAddr;
        logic [63:0] expWrData;
        logic        expBusy;
        logic [1:0]  expGrant;
        logic [3:0]  expRdAck;
        logic [3:0]  expWrAck;
        logic [63:0] expRdData;
    } vector_t;

    vector_t vectors [10];

    // Compare one value and tally the result.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one table row at a falling edge and check outputs one edge later.
    task automatic applyStimulus(input vector_t v, input int idx);
        laneReadValid  = v.readValid;
        laneWriteValid = v.writeValid;
        memReadAck     = v.mRdAck;
        memWriteAck    = v.mWrAck;
        memReadData    = v.mRdData;
        @(negedge clk);
        checkOutput($sformatf("vec%0d.memReadValid", idx), 64'(mem_read_valid), 64'(v.expRdValid));
        checkOutput($sformatf("vec%0d.memWriteValid", idx), 64'(mem_write_valid), 64'(v.expWrValid));
        checkOutput($sformatf("vec%0d.memAddr", idx), 64'(mem_addr), 64'(v.expAddr));
        checkOutput($sformatf("vec%0d.memWriteData", idx), mem_write_data, v.expWrData);
        checkOutput($sformatf("vec%0d.busy", idx), 64'(busy), 64'(v.expBusy));
        checkOutput($sformatf("vec%0d.grantLane", idx), 64'(grant_lane), 64'(v.expGrant));
        checkOutput($sformatf("vec%0d.laneReadAck", idx), 64'(lane_read_ack), 64'(v.expRdAck));
        checkOutput($sformatf("vec%0d.laneWriteAck", idx), 64'(lane_write_ack), 64'(v.expWrAck));
        checkOutput($sformatf("vec%0d.laneReadData", idx), lane_read_data, v.expRdData);
    endtask

    // Act as memory for one transaction: wait (bounded) for the request,
    // check it, optionally inject an ack of the wrong type, ack after two
    // cycles and check the lane-side pulse. Returns at the falling edge where
    // the lane ack is visible; the lane drops its valid there unless held.
    task automatic serveTxn(input int lane, input bit isRead, input logic [63:0] rd,
                            input bit stray, input bit holdValid);
        int n;
        n = 0;
        while (!(mem_read_valid || mem_write_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("requestSeen", 64'(mem_read_valid | mem_write_valid), 64'd1);
        if (!(mem_read_valid || mem_write_valid)) return;
        checkOutput("grantLane", 64'(grant_lane), 64'(lane));
        checkOutput("memAddr", 64'(mem_addr), 64'(laneAddr[lane]));
        checkOutput("memReadValid", 64'(mem_read_valid), 64'(isRead));
        checkOutput("memWriteValid", 64'(mem_write_valid), 64'(!isRead));
        if (!isRead) checkOutput("memWriteData", mem_write_data, laneData[lane]);
        if (stray) begin
            if (isRead) memWriteAck = 1'b1;
            else memReadAck = 1'b1;
            @(negedge clk);
            memWriteAck = 1'b0;
            memReadAck  = 1'b0;
            checkOutput("strayIgnored", 64'({mem_read_valid, mem_write_valid}), isRead ? 64'd2 : 64'd1);
            checkOutput("strayNoAck", 64'(lane_read_ack | lane_write_ack), 64'd0);
        end
        @(negedge clk);
        checkOutput("memAddrHeld", 64'(mem_addr), 64'(laneAddr[lane]));
        if (isRead) begin
            memReadAck  = 1'b1;
            memReadData = rd;
        end else begin
            memWriteAck = 1'b1;
        end
        @(negedge clk);
        memReadAck  = 1'b0;
        memWriteAck = 1'b0;
        memReadData = 64'h0BAD;
        checkOutput("laneReadAck", 64'(lane_read_ack), isRead ? (64'd1 << lane) : 64'd0);
        checkOutput("laneWriteAck", 64'(lane_write_ack), isRead ? 64'd0 : (64'd1 << lane));
        if (isRead) checkOutput("laneReadData", lane_read_data, rd);
        if (!holdValid) begin
            if (isRead) laneReadValid[lane] = 1'b0;
            else laneWriteValid[lane] = 1'b0;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int snap [NL];
        int n;

        // Single-lane read then single-lane write, one row per clock.
        //             rdV     wrV     mRA   mWA   mRdData                  eRV   eWV   eAddr  eWData    eBusy eGnt  eRAck   eWAck   eRdData
        vectors[0] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 64'h0BAD,               1'b1, 1'b0, 7'h15, 64'h5555, 1'b1, 2'd2, 4'b0000, 4'b0000, 64'h0};
        vectors[1] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 64'h0BAD,               1'b1, 1'b0, 7'h15, 64'h5555, 1'b1, 2'd2, 4'b0000, 4'b0000, 64'h0};
        vectors[2] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 64'h0BAD,               1'b1, 1'b0, 7'h15, 64'h5555, 1'b1, 2'd2, 4'b0000, 4'b0000, 64'h0};
        vectors[3] = '{4'b0100, 4'b0000, 1'b1, 1'b0, 64'hDEADBEEF_00000001,  1'b0, 1'b0, 7'h15, 64'h5555, 1'b1, 2'd2, 4'b0100, 4'b0000, 64'hDEADBEEF_00000001};
        vectors[4] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 64'h0BAD,               1'b0, 1'b0, 7'h15, 64'h5555, 1'b0, 2'd2, 4'b0000, 4'b0000, 64'hDEADBEEF_00000001};
        vectors[5] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 64'h0BAD,               1'b0, 1'b0, 7'h15, 64'h5555, 1'b0, 2'd2, 4'b0000, 4'b0000, 64'hDEADBEEF_00000001};
        vectors[6] = '{4'b0000, 4'b0010, 1'b0, 1'b0, 64'h0BAD,               1'b0, 1'b1, 7'h0A, 64'h1234, 1'b1, 2'd1, 4'b0000, 4'b0000, 64'hDEADBEEF_00000001};
        vectors[7] = '{4'b0000, 4'b0010, 1'b0, 1'b0, 64'h0BAD,               1'b0, 1'b1, 7'h0A, 64'h1234, 1'b1, 2'd1, 4'b0000, 4'b0000, 64'hDEADBEEF_00000001};
        vectors[8] = '{4'b0000, 4'b0010, 1'b0, 1'b1, 64'h0BAD,               1'b0, 1'b0, 7'h0A, 64'h1234, 1'b1, 2'd1, 4'b0000, 4'b0010, 64'hDEADBEEF_00000001};
        vectors[9] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 64'h0BAD,               1'b0, 1'b0, 7'h0A, 64'h1234, 1'b0, 2'd1, 4'b0000, 4'b0000, 64'hDEADBEEF_00000001};

        rst            = 1'b1;
        laneReadValid  = '0;
        laneWriteValid = '0;
        memReadAck     = 1'b0;
        memWriteAck    = 1'b0;
        memReadData    = 64'h0BAD;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst.memValids", 64'({mem_read_valid, mem_write_valid}), 64'd0);
        checkOutput("rst.busy", 64'(busy), 64'd0);
        checkOutput("rst.grantLane", 64'(grant_lane), 64'd0);
        checkOutput("rst.laneAcks", 64'({lane_read_ack, lane_write_ack}), 64'd0);
        checkOutput("rst.laneReadData", lane_read_data, 64'd0);
        checkOutput("rst.memAddr", 64'(mem_addr), 64'd0);
        rst = 1'b0;

        $display("[TB] single read and single write vectors");
        for (int i = 0; i < 10; i++) applyStimulus(vectors[i], i);

        $display("[TB] all lanes read together");
        doReset();
        for (int i = 0; i < NL; i++) snap[i] = ackCount[i];
        laneReadValid = 4'b1111;
        for (int i = 0; i < NL; i++) serveTxn(i, 1'b1, 64'hC0DE_0000 + 64'(i), 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < NL; i++)
            checkOutput($sformatf("allLanes.ackCount%0d", i), 64'(ackCount[i] - snap[i]), 64'd1);

        $display("[TB] lane 3 holds valid past its ack while lane 0 waits");
        laneReadValid[3] = 1'b1;
        @(negedge clk);
        laneReadValid[0] = 1'b1;
        for (int i = 0; i < NL; i++) snap[i] = ackCount[i];
        serveTxn(3, 1'b1, 64'h3333, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        laneReadValid[3] = 1'b0;
        serveTxn(0, 1'b1, 64'h0000_0000_0000_00F0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("lateDrop.lane3Once", 64'(ackCount[3] - snap[3]), 64'd1);
        checkOutput("lateDrop.lane0Once", 64'(ackCount[0] - snap[0]), 64'd1);
        checkOutput("lateDrop.idle", 64'(busy), 64'd0);

        $display("[TB] lone lane holds valid past its ack");
        laneReadValid[3] = 1'b1;
        serveTxn(3, 1'b1, 64'h4444, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mask.noRegrantBusy", 64'(busy), 64'd0);
        checkOutput("mask.noRegrantValid", 64'(mem_read_valid), 64'd0);
        laneReadValid[3] = 1'b0;
        @(negedge clk);
        checkOutput("mask.stillIdle", 64'(busy), 64'd0);

        $display("[TB] reset during a read wait");
        laneReadValid[1] = 1'b1;
        serveTxn(1, 1'b1, 64'h1111, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < NL; i++) snap[i] = ackCount[i];
        laneReadValid[2] = 1'b1;
        n = 0;
        while (!mem_read_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort.requestSeen", 64'(mem_read_valid), 64'd1);
        checkOutput("abort.grant", 64'(grant_lane), 64'd2);
        rst = 1'b1;
        laneReadValid[2] = 1'b0;
        @(negedge clk);
        checkOutput("abort.memReadValid", 64'(mem_read_valid), 64'd0);
        checkOutput("abort.busy", 64'(busy), 64'd0);
        checkOutput("abort.laneAcks", 64'({lane_read_ack, lane_write_ack}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NL; i++)
            checkOutput($sformatf("abort.noAck%0d", i), 64'(ackCount[i] - snap[i]), 64'd0);
        laneReadValid[1] = 1'b1;
        laneReadValid[3] = 1'b1;
        serveTxn(1, 1'b1, 64'h5151, 1'b0, 1'b0);
        serveTxn(3, 1'b1, 64'h5353, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] lane 0 read and write together with a stray write ack");
        laneReadValid[0]  = 1'b1;
        laneWriteValid[0] = 1'b1;
        serveTxn(0, 1'b1, 64'hFEED_0000_0000_0006, 1'b1, 1'b0);
        serveTxn(0, 1'b0, 64'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("collide.idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
